// File: rtl/rv_stream_source.sv
// ---------------------------------------------------------------------------
// rv_stream_source
//   Ready/valid burst transmitter. On an honoured start it emits num_tokens
//   tokens forming the arithmetic sequence start_value, start_value+STEP, ...
//   (mod 2^DATA_WIDTH). Once out_valid is raised, out_data/out_valid hold
//   until the token is accepted. All outputs are registered.
//
//   Optional build macro: RV_SOURCE_THROTTLE_EN
//     Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11) that randomly delays
//     raising out_valid between tokens. It never withdraws a raised valid.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   one-cycle burst request, honoured only in IDLE
//   num_tokens   in   [CNT_W]      burst length, sampled with start
//   start_value  in   [DATA_WIDTH] first token value, sampled with start
//   out_data     out  [DATA_WIDTH] token value
//   out_valid    out  token present
//   out_ready    in   downstream accepts token this cycle
//   busy         out  high while sending a burst
//   done         out  one-cycle pulse after the last token is accepted
//   sent_count   out  [CNT_W]      tokens accepted in current/last burst
// ---------------------------------------------------------------------------
module rv_stream_source #(
    parameter int          DATA_WIDTH = 8,
    parameter int          CNT_W      = 16,
    parameter int          STEP       = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_tokens,
    input  logic [DATA_WIDTH-1:0] start_value,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      sent_count
);

    localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);
    localparam logic [CNT_W-1:0]      ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      remaining, remaining_n;
    logic [CNT_W-1:0]      sent_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  xfer;
    // Permission to raise out_valid at the next edge when it is currently low.
    logic                  gate;

    // out_valid is only ever high in SEND, so this is the whole handshake.
    assign xfer = out_valid & out_ready;

`ifdef RV_SOURCE_THROTTLE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (state == S_SEND) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign gate = lfsr[0];
`else
    assign gate = 1'b1;
`endif

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            sent_count <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            sent_count <= sent_n;
            out_data   <= data_n;
            out_valid  <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state and next-output logic. The token value lives directly in
    // the out_data register, so holding it during a stall is the default.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        sent_n      = sent_count;
        data_n      = out_data;
        valid_n     = out_valid;
        busy_n      = busy;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (start) begin
                    sent_n = '0;
                    if (num_tokens != '0) begin
                        data_n      = start_value;
                        remaining_n = num_tokens;
                        valid_n     = gate;
                        busy_n      = 1'b1;
                        state_n     = S_SEND;
                    end else begin
                        // Empty burst: straight to the completion pulse.
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end

            S_SEND: begin
                busy_n = 1'b1;
                if (xfer) begin
                    data_n      = out_data + STEP_V;
                    remaining_n = remaining - ONE;
                    sent_n      = sent_count + ONE;
                    if (remaining == ONE) begin
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        valid_n = gate;
                    end
                end else if (!out_valid) begin
                    // Only a low valid may be raised; a high one holds.
                    valid_n = gate;
                end
            end

            S_DONE: begin
                // start is deliberately ignored here.
                valid_n = 1'b0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end

            default: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_stream_source.sv
module tb_rv_stream_source;

    localparam int DW   = 8;
    localparam int CW   = 16;
    localparam int STEP = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_tokens;
    logic [DW-1:0] start_value;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] sent_count;

    int checks = 0;
    int passed = 0;

    // Observations from run_burst.
    logic [DW-1:0] got[$];
    int            r_dones;
    int            r_hold_err;
    int            r_valid_err;
    bit            r_timeout;
    logic [CW-1:0] r_final_cnt;

    rv_stream_source dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_tokens (num_tokens),
        .start_value(start_value),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: k-th token of a burst.
    function automatic logic [DW-1:0] exp_tok(input logic [DW-1:0] sv, input int k);
        return DW'((int'(sv) + k * STEP) % (1 << DW));
    endfunction

    // Launch a burst and observe it until done falls, with out_ready high
    // with probability ready_pct. Inputs are scrambled after the start cycle.
    task automatic run_burst(input int n, input logic [DW-1:0] sv, input int ready_pct);
        bit            seen;
        bit            r;
        bit            pv;
        logic [DW-1:0] pd;
        got.delete();
        r_dones = 0; r_hold_err = 0; r_valid_err = 0; r_timeout = 1'b0;
        r_final_cnt = '0; seen = 1'b0;
        start = 1'b1; num_tokens = CW'(n); start_value = sv;
        out_ready = ($urandom_range(99) < ready_pct);
        step();
        start = 1'b0;
        num_tokens = CW'($urandom); start_value = DW'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if (done) begin
                r_dones++; seen = 1'b1; r_final_cnt = sent_count;
            end else if (seen) begin
                break;
            end
            r = ($urandom_range(99) < ready_pct);
            out_ready = r;
            pv = out_valid; pd = out_data;
            if (pv && r) got.push_back(pd);
            if (out_valid && !busy) r_valid_err++;
            step();
            if (pv && !r && !(out_valid === 1'b1 && out_data === pd)) r_hold_err++;
        end
        if (!seen) r_timeout = 1'b1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_tokens = '0; start_value = '0; out_ready = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", out_valid); else passed++;
        checks++; if (out_data !== 8'h00) $display("FAIL reset_data got=%02h exp=00", out_data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else passed++;
        checks++; if (sent_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", sent_count); else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        start = 1'b1; num_tokens = 16'd4; start_value = 8'h10; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tok(8'h10, i) || busy !== 1'b1)
                $display("FAIL basic_tok%0d got v=%0b d=%02h b=%0b exp v=1 d=%02h b=1",
                         i, out_valid, out_data, busy, exp_tok(8'h10, i));
            else passed++;
            step();
        end
        checks++; if (out_valid !== 1'b0 || done !== 1'b1)
            $display("FAIL basic_end got v=%0b done=%0b exp v=0 done=1", out_valid, done); else passed++;
        checks++; if (sent_count !== 16'd4) $display("FAIL basic_count got=%0d exp=4", sent_count); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy got=%0b exp=0", busy); else passed++;
        step();
        checks++; if (done !== 1'b0) $display("FAIL basic_done_width got=%0b exp=0", done); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int stalls;
        logic [DW-1:0] q[$];
        bit ok;
        start = 1'b1; num_tokens = 16'd3; start_value = 8'h00; out_ready = 1'b1;
        step();
        start = 1'b0;
        stalls = 0; ok = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (out_valid && out_data == 8'h01 && stalls < 3) begin
                out_ready = 1'b0; stalls++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) q.push_back(out_data);
            step();
            if (!out_ready && !(out_valid === 1'b1 && out_data === 8'h01)) ok = 1'b0;
        end
        checks++; if (!ok || stalls != 3) $display("FAIL bp_hold ok=%0b stalls=%0d exp ok=1 stalls=3", ok, stalls); else passed++;
        checks++; if (q.size() != 3) $display("FAIL bp_len got=%0d exp=3", q.size()); else passed++;
        for (int i = 0; i < q.size() && i < 3; i++) begin
            checks++; if (q[i] !== exp_tok(8'h00, i))
                $display("FAIL bp_tok%0d got=%02h exp=%02h", i, q[i], exp_tok(8'h00, i)); else passed++;
        end
        checks++; if (done !== 1'b1 || sent_count !== 16'd3)
            $display("FAIL bp_done got done=%0b cnt=%0d exp done=1 cnt=3", done, sent_count); else passed++;
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        run_burst(3, 8'hFE, 100);
        checks++; if (r_timeout || got.size() != 3) $display("FAIL wrap_len got=%0d to=%0b exp=3", got.size(), r_timeout); else passed++;
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++; if (got[i] !== exp_tok(8'hFE, i))
                $display("FAIL wrap_tok%0d got=%02h exp=%02h", i, got[i], exp_tok(8'hFE, i)); else passed++;
        end
    endtask

    task automatic test_zero_length();
        bit vseen, bseen;
        start = 1'b1; num_tokens = 16'd0; start_value = 8'h55; out_ready = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1) $display("FAIL zero_done got=%0b exp=1", done); else passed++;
        checks++; if (sent_count !== 16'd0) $display("FAIL zero_count got=%0d exp=0", sent_count); else passed++;
        vseen = out_valid; bseen = busy;
        for (int c = 0; c < 5; c++) begin
            step();
            vseen |= out_valid; bseen |= busy;
            if (c == 0) begin
                checks++; if (done !== 1'b0) $display("FAIL zero_done_width got=%0b exp=0", done); else passed++;
            end
        end
        checks++; if (vseen || bseen) $display("FAIL zero_quiet got valid=%0b busy=%0b exp 0 0", vseen, bseen); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_ignored_start();
        logic [DW-1:0] sv;
        logic [DW-1:0] q[$];
        int dn;
        sv = DW'($urandom);
        start = 1'b1; num_tokens = 16'd5; start_value = sv; out_ready = 1'b1;
        step();
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            // Re-request a different burst during SEND and in DONE.
            start = (c == 1 || c == 3 || done);
            num_tokens = 16'd9; start_value = sv + 8'h40;
            if (done) dn++;
            if (out_valid) q.push_back(out_data);
            step();
        end
        start = 1'b0;
        checks++; if (q.size() != 5 || dn != 1) $display("FAIL ign_len got=%0d dones=%0d exp=5 dones=1", q.size(), dn); else passed++;
        for (int i = 0; i < q.size() && i < 5; i++) begin
            checks++; if (q[i] !== exp_tok(sv, i))
                $display("FAIL ign_tok%0d got=%02h exp=%02h", i, q[i], exp_tok(sv, i)); else passed++;
        end
        checks++; if (sent_count !== 16'd5 || busy !== 1'b0)
            $display("FAIL ign_count got cnt=%0d busy=%0b exp cnt=5 busy=0", sent_count, busy); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        bit anyv, anyd;
        start = 1'b1; num_tokens = 16'd5; start_value = 8'h30; out_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        checks++; if (sent_count !== 16'd2 || out_data !== 8'h32)
            $display("FAIL rmid_pre got cnt=%0d d=%02h exp cnt=2 d=32", sent_count, out_data); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || sent_count !== 16'd0)
            $display("FAIL rmid_post got v=%0b b=%0b cnt=%0d exp 0 0 0", out_valid, busy, sent_count); else passed++;
        anyv = 1'b0; anyd = done;
        for (int c = 0; c < 10; c++) begin
            step();
            anyv |= out_valid; anyd |= done;
        end
        checks++; if (anyv || anyd) $display("FAIL rmid_abandon got valid=%0b done=%0b exp 0 0", anyv, anyd); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Second burst requested in the first IDLE cycle after completion.
        run_burst(2, 8'h70, 100);
        run_burst(3, 8'h80, 100);
        checks++; if (r_timeout || got.size() != 3 || r_dones != 1)
            $display("FAIL b2b_len got=%0d dones=%0d exp=3 dones=1", got.size(), r_dones); else passed++;
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++; if (got[i] !== exp_tok(8'h80, i))
                $display("FAIL b2b_tok%0d got=%02h exp=%02h", i, got[i], exp_tok(8'h80, i)); else passed++;
        end
    endtask

    task automatic test_random_bursts();
        int n, pct, bad;
        logic [DW-1:0] sv;
        for (int b = 0; b < 10; b++) begin
            n = $urandom_range(20, 1);
            sv = DW'($urandom);
            pct = $urandom_range(90, 20);
            run_burst(n, sv, pct);
            bad = -1;
            for (int i = 0; i < got.size(); i++)
                if (bad < 0 && got[i] !== exp_tok(sv, i)) bad = i;
            checks++; if (r_timeout || got.size() != n || bad >= 0)
                $display("FAIL rand%0d_seq got len=%0d exp len=%0d first_bad=%0d timeout=%0b", b, got.size(), n, bad, r_timeout);
            else passed++;
            checks++; if (r_final_cnt !== CW'(n) || r_dones != 1)
                $display("FAIL rand%0d_done got cnt=%0d dones=%0d exp cnt=%0d dones=1", b, r_final_cnt, r_dones, n);
            else passed++;
            checks++; if (r_hold_err != 0 || r_valid_err != 0)
                $display("FAIL rand%0d_proto got hold_err=%0d valid_err=%0d exp 0 0", b, r_hold_err, r_valid_err);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_ignored_start();
        test_reset_mid_burst();
        test_back_to_back();
        test_random_bursts();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
